inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: start  in  1  level; leaves IDLE and begins fetching at pc.
REQ-005 Port: imem_req / imem_ack  out / in  1 / 1  instruction fetch handshake; imem_addr = pc.
REQ-006 Port: imem_data  in  32  instruction word, valid when imem_ack=1.
REQ-007 Port: inst  out  32  instruction register (IR) feeding the decoder.
REQ-008 Port: dec_reg_we, dec_data_we, dec_branch[1:0], dec_branch_dir, dec_branch_off[4:0]  in  decoder outputs for IR.
REQ-009 Port: alu_zero, alu_neg  in  1  ALU flags from the rs1-rs2 result.
REQ-010 Port: pc  out  5  program counter and imem address.
REQ-011 Port: reg_we_strobe, data_we_strobe  out  1  one-cycle write qualifiers.
REQ-012 Port: busy, halted  out  1  status.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 IDLE: start=1 -> FETCH; otherwise hold.
REQ-015 FETCH: imem_req=1 until imem_ack=1; on ack, IR<=imem_data and go to DECODE; wait states unbounded.
REQ-016 DECODE: IR[6:0] in {0000011, 0100011, 0110011, 1100011} -> EXEC; any other opcode -> HALT with pc unchanged.
REQ-017 EXEC: branch (dec_branch!=00) -> FETCH with pc update; ld/sd -> MEM; R-type -> WB.
REQ-018 MEM: data_we_strobe=dec_data_we for exactly one cycle; ld -> WB; sd -> FETCH, pc+1.
REQ-019 WB: reg_we_strobe=dec_reg_we for exactly one cycle; -> FETCH, pc+1.
REQ-020 Branch taken iff (dec_branch=01 & alu_zero) | (dec_branch=10 & alu_neg), sampled in EXEC.
REQ-021 Taken: pc <= pc - off if dec_branch_dir=1, else pc + off; not taken: pc+1; mod 32, carry and borrow discarded.
REQ-022 pc 31 + 1 SHALL wrap to 0; offset 0 taken SHALL re-fetch the same pc.
REQ-023 Cycles per instruction with zero-wait fetch: branch 3, R-type 4, sd 4, ld 5.
REQ-024 busy=1 in every state except IDLE and HALT; halted=1 only in HALT.
REQ-025 HALT is left only by reset; start is ignored outside IDLE.
REQ-026 Strobes SHALL never both be 1, and SHALL never assert outside MEM/WB.

Reset
REQ-027 Reset SHALL give state=IDLE, pc=0, inst=0, imem_req=0, all strobes 0, busy=0, halted=0.
REQ-028 Reset asserted mid-FETCH SHALL drop imem_req immediately; a late imem_ack SHALL be ignored.

Configuration
REQ-029 With SEQ_PERF_CNT_EN defined: add outputs cycle_cnt[31:0] (+1 each cycle busy=1) and retired_cnt[31:0] (+1 on each completed instruction), both saturating and reset to 0.
REQ-030 Without SEQ_PERF_CNT_EN: those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-031 Shared package core_pkg SHALL hold the state enum, the opcode constants, the dec_branch encodings (00 none, 01 beq, 10 blt) and the PC width constant (5).
REQ-032 One sub-module, pc_unit (next-pc adder/mux), is natural; the FSM stays in inst_sequencer.

Verification
REQ-033 Reset, start=1, zero-wait ack, IR=add x3,x1,x2 -> reg_we_strobe pulses in cycle 4, pc 0->1.
REQ-034 ld then sd at pc 0,1 -> ld takes 5 cycles and sd 4; data_we_strobe pulses only during sd's MEM.
REQ-035 beq at pc 4, alu_zero=1, off=3, dir=1 -> pc=1; same with alu_zero=0 -> pc=5.
REQ-036 blt at pc 30, alu_neg=1, off=5, dir=0 -> pc=3 (wrap); nop add at pc 31 -> pc=0.
REQ-037 imem_ack held low 7 cycles -> imem_req held high, state FETCH; reset in cycle 3 -> IDLE, pc=0.
REQ-038 IR opcode 1111111 -> HALT, halted=1, pc unchanged, start ignored until rst_n low.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the FSM state encoding, opcodes, branch encodings and PC width.
package core_pkg;

    localparam int PC_W = 5;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } seq_state_t;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_LT   = 2'b10;

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_SD) ||
               (op == OP_R)  || (op == OP_BR);
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Next-PC selection: sequential increment or relative branch target.
// Arithmetic is modulo 2**PC_W; carry and borrow fall off the top.
module pc_unit
    import core_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic            taken,
    input  logic            dir,
    input  logic [4:0]      off,
    output logic [PC_W-1:0] next_pc
);

    // Backward branches subtract the offset, forward ones add it.
    always_comb begin
        next_pc = pc + PC_ONE;
        if (taken) begin
            next_pc = dir ? (pc - off) : (pc + off);
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with a 5-bit PC.
// Optional perf counters (cycle_cnt, retired_cnt) under SEQ_PERF_CNT_EN.
module inst_sequencer
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     inst,
    input  logic            dec_reg_we,
    input  logic            dec_data_we,
    input  logic [1:0]      dec_branch,
    input  logic            dec_branch_dir,
    input  logic [4:0]      dec_branch_off,
    input  logic            alu_zero,
    input  logic            alu_neg,
    output logic [PC_W-1:0] pc,
    output logic            reg_we_strobe,
    output logic            data_we_strobe,
    output logic            busy,
    output logic            halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     retired_cnt
`endif
);

    seq_state_t      state;
    seq_state_t      next_state;
    logic            ir_load;
    logic            pc_load;
    logic            retire;
    logic            taken;
    logic [PC_W-1:0] next_pc;
    logic [6:0]      op;

    assign op = inst[6:0];

    pc_unit u_pc (
        .pc      (pc),
        .taken   (taken),
        .dir     (dec_branch_dir),
        .off     (dec_branch_off),
        .next_pc (next_pc)
    );

    // State register; reset kills an in-flight fetch at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus request, strobe and status outputs.
    always_comb begin
        next_state     = state;
        imem_req       = 1'b0;
        reg_we_strobe  = 1'b0;
        data_we_strobe = 1'b0;
        ir_load        = 1'b0;
        pc_load        = 1'b0;
        retire         = 1'b0;
        taken          = 1'b0;
        busy           = (state != S_IDLE) && (state != S_HALT);
        halted         = (state == S_HALT);
        unique case (state)
            S_IDLE: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                next_state = op_known(op) ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (dec_branch != BR_NONE) begin
                    taken = ((dec_branch == BR_EQ) && alu_zero) ||
                            ((dec_branch == BR_LT) && alu_neg);
                    pc_load    = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if ((op == OP_LD) || (op == OP_SD)) begin
                    next_state = S_MEM;
                end else if (op == OP_R) begin
                    next_state = S_WB;
                end else begin
                    pc_load    = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEM: begin
                data_we_strobe = dec_data_we;
                if (op == OP_LD) begin
                    next_state = S_WB;
                end else begin
                    pc_load    = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_WB: begin
                reg_we_strobe = dec_reg_we;
                pc_load       = 1'b1;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Program counter advances only when an instruction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (pc_load) begin
            pc <= next_pc;
        end
    end

    // Instruction register captures the word on fetch acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst <= '0;
        end else if (ir_load) begin
            inst <= imem_data;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Saturating busy-cycle and retired-instruction counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (busy && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retire && (retired_cnt != '1)) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: instruction-level model feeds
// expected fetch/strobe/CPI events, a monitor compares DUT activity.
module tb_inst_sequencer;

    localparam logic [6:0] T_LD = 7'b0000011;
    localparam logic [6:0] T_SD = 7'b0100011;
    localparam logic [6:0] T_R  = 7'b0110011;
    localparam logic [6:0] T_BR = 7'b1100011;
    localparam logic [6:0] T_BAD = 7'b1111111;

    localparam int EV_FETCH = 0;
    localparam int EV_REG   = 1;
    localparam int EV_DATA  = 2;
    localparam int EV_CPI   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic        dec_reg_we;
    logic        dec_data_we;
    logic [1:0]  dec_branch;
    logic        dec_branch_dir;
    logic [4:0]  dec_branch_off;
    logic        alu_zero;
    logic        alu_neg;
    logic [4:0]  pc;
    logic        reg_we_strobe;
    logic        data_we_strobe;
    logic        busy;
    logic        halted;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;
`endif

    always #5 clk = ~clk;

    inst_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_req       (imem_req),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .inst           (inst),
        .dec_reg_we     (dec_reg_we),
        .dec_data_we    (dec_data_we),
        .dec_branch     (dec_branch),
        .dec_branch_dir (dec_branch_dir),
        .dec_branch_off (dec_branch_off),
        .alu_zero       (alu_zero),
        .alu_neg        (alu_neg),
        .pc             (pc),
        .reg_we_strobe  (reg_we_strobe),
        .data_we_strobe (data_we_strobe),
        .busy           (busy),
        .halted         (halted)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt      (cycle_cnt),
        .retired_cnt    (retired_cnt)
`endif
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    typedef struct {
        logic [31:0] w;
        logic        z;
        logic        n;
    } di_t;

    ev_t expq[$];
    di_t dq[$];

    int checks = 0;
    int failures = 0;
    int mpc = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic rwe, input logic dwe,
                                       input logic [1:0] br,
                                       input logic dir,
                                       input logic [4:0] off);
        logic [31:0] w;
        w        = 32'h0;
        w[6:0]   = op;
        w[13:12] = br;
        w[14]    = dir;
        w[19:15] = off;
        w[20]    = rwe;
        w[21]    = dwe;
        w[31:22] = 10'($urandom);
        return w;
    endfunction

    function automatic di_t mkd(input logic [31:0] w, input logic z,
                                input logic n);
        di_t d;
        d.w = w;
        d.z = z;
        d.n = n;
        return d;
    endfunction

    function automatic di_t rand_inst();
        int k;
        logic [31:0] w;
        k = $urandom_range(0, 3);
        case (k)
            0: w = mk(T_LD, 1'($urandom), 1'b0, 2'b00, 1'b0, 5'd0);
            1: w = mk(T_SD, 1'b0, 1'($urandom), 2'b00, 1'b0, 5'd0);
            2: w = mk(T_R, 1'($urandom), 1'b0, 2'b00, 1'b0, 5'd0);
            default: w = mk(T_BR, 1'b0, 1'b0,
                            2'($urandom_range(1, 2)),
                            1'($urandom), 5'($urandom));
        endcase
        return mkd(w, 1'($urandom), 1'($urandom));
    endfunction

    // Monitor: turns DUT activity into events and scores them.
    task automatic got(input int kind, input int val);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL event: unexpected kind=%0d val=%0d",
                     kind, val);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL event: got kind=%0d val=%0d expected kind=%0d val=%0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    initial begin
        int cyc;
        int last_cyc;
        bit have_last;
        bit prev_req;
        cyc = 0;
        last_cyc = 0;
        have_last = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n || !mon_en) begin
                have_last = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (imem_req && !prev_req && have_last) begin
                    got(EV_CPI, cyc - last_cyc);
                end
                if (imem_req && imem_ack) begin
                    got(EV_FETCH, int'(pc));
                    last_cyc = cyc;
                    have_last = 1'b1;
                end
                if (reg_we_strobe) got(EV_REG, 0);
                if (data_we_strobe) got(EV_DATA, 0);
                if (reg_we_strobe || data_we_strobe) begin
                    chk("strobes_exclusive",
                        32'(reg_we_strobe & data_we_strobe), 32'd0);
                end
                prev_req = imem_req;
            end
        end
    end

    // Instruction-level reference: expected events and next pc.
    task automatic model(input di_t d, output bit hlt);
        logic [6:0] op;
        logic [1:0] br;
        int off;
        bit tk;
        op  = d.w[6:0];
        br  = d.w[13:12];
        off = int'(d.w[19:15]);
        hlt = 1'b0;
        expq.push_back('{EV_FETCH, mpc});
        if (op == T_BR && br != 2'b00) begin
            tk = (br == 2'b01 && d.z) || (br == 2'b10 && d.n);
            if (!tk) mpc = (mpc + 1) % 32;
            else if (d.w[14]) mpc = (mpc - off + 32) % 32;
            else mpc = (mpc + off) % 32;
            expq.push_back('{EV_CPI, 3});
        end else if (op == T_LD) begin
            if (d.w[20]) expq.push_back('{EV_REG, 0});
            expq.push_back('{EV_CPI, 5});
            mpc = (mpc + 1) % 32;
        end else if (op == T_SD) begin
            if (d.w[21]) expq.push_back('{EV_DATA, 0});
            expq.push_back('{EV_CPI, 4});
            mpc = (mpc + 1) % 32;
        end else if (op == T_R) begin
            if (d.w[20]) expq.push_back('{EV_REG, 0});
            expq.push_back('{EV_CPI, 4});
            mpc = (mpc + 1) % 32;
        end else begin
            hlt = 1'b1;
        end
    endtask

    // Fetch responder plus decoder/ALU stand-in for one instruction.
    task automatic feed(input di_t d, output bit stop);
        int t;
        int w;
        logic [6:0] op;
        t = 0;
        stop = 1'b0;
        while (!imem_req && t < 50) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (!imem_req) begin
            failures++;
            $display("FAIL fetch_timeout: imem_req=0 expected 1");
            stop = 1'b1;
            return;
        end
        w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        repeat (w) begin
            @(posedge clk);
            #2;
        end
        op = d.w[6:0];
        imem_ack       = 1'b1;
        imem_data      = d.w;
        dec_reg_we     = ((op == T_LD) || (op == T_R)) & d.w[20];
        dec_data_we    = (op == T_SD) & d.w[21];
        dec_branch     = (op == T_BR) ? d.w[13:12] : 2'b00;
        dec_branch_dir = d.w[14];
        dec_branch_off = d.w[19:15];
        alu_zero       = d.z;
        alu_neg        = d.n;
        model(d, stop);
        @(posedge clk);
        #2;
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        start  = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        mpc = 0;
    endtask

    task automatic run(input int nrand);
        bit stop;
        di_t d;
        do_reset();
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b1;
        stop = 1'b0;
        for (int i = 0; i < 400 && !stop; i++) begin
            if (dq.size() > 0) d = dq.pop_front();
            else if (nrand > 0) begin
                d = rand_inst();
                nrand--;
            end else begin
                d = mkd(mk(T_BAD, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0),
                        1'b0, 1'b0);
            end
            feed(d, stop);
        end
        repeat (5) @(negedge clk);
        chk("halted", 32'(halted), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_pc", 32'(pc), 32'(mpc));
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        mon_en = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        imem_ack = 1'b0;
        imem_data = 32'h0;
        dec_reg_we = 1'b0;
        dec_data_we = 1'b0;
        dec_branch = 2'b00;
        dec_branch_dir = 1'b0;
        dec_branch_off = 5'd0;
        alu_zero = 1'b0;
        alu_neg = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_reg_we", 32'(reg_we_strobe), 32'd0);
        chk("rst_data_we", 32'(data_we_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;

        @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_busy", 32'(busy), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("midfetch_req", 32'(imem_req), 32'd0);
        chk("midfetch_pc", 32'(pc), 32'd0);
        chk("midfetch_busy", 32'(busy), 32'd0);
        imem_ack = 1'b1;
        imem_data = mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_inst", inst, 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b0;

        dq.push_back(mkd(mk(T_LD, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_SD, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_BR, 1'b0, 1'b0, 2'b01, 1'b1, 5'd3), 1, 0));
        dq.push_back(mkd(mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_BR, 1'b0, 1'b0, 2'b01, 1'b1, 5'd3), 0, 1));
        run(120);

        dq.push_back(mkd(mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_BR, 1'b0, 1'b0, 2'b01, 1'b0, 5'd29), 1, 0));
        dq.push_back(mkd(mk(T_BR, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5), 0, 1));
        dq.push_back(mkd(mk(T_BR, 1'b0, 1'b0, 2'b01, 1'b1, 5'd4), 1, 0));
        dq.push_back(mkd(mk(T_R, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_BR, 1'b0, 1'b0, 2'b01, 1'b0, 5'd0), 1, 0));
        dq.push_back(mkd(mk(T_R, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        dq.push_back(mkd(mk(T_SD, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0), 0, 0));
        run(120);

        run(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
